// File: rtl/shield_meter_bank_pkg.sv
// Shared game package: meter state encoding, default meter constants and
// a small sizing helper used by the shield meters, player FSMs and HUD logic.
package shield_meter_bank_pkg;

   // Per-channel meter states.
   typedef enum logic [2:0] {
      ST_READY  = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_DELAY  = 3'd2,
      ST_REGEN  = 3'd3,
      ST_BROKEN = 3'd4
   } meter_state_e;

   // Default meter constants.
   localparam int DEF_NUM_CH      = 2;
   localparam int DEF_W           = 4;
   localparam int DEF_MAX_LVL     = 15;
   localparam int DEF_DRAIN_STEP  = 1;
   localparam int DEF_REGEN_STEP  = 1;
   localparam int DEF_REGEN_DELAY = 2;
   localparam int DEF_BREAK_TICKS = 4;
   localparam int DEF_MIN_USE     = 1;
   localparam int DEF_SYNC_STAGES = 2;

   // Bits needed for a down-counter loaded with n-1 (never narrower than 1).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shield_meter_bank_if.sv
// Shield meter bus: fast-domain hold requests in, per-channel meter status out.
// The master side is player/HUD logic; the slave side is the meter bank.
interface shield_meter_bank_if #(
   parameter int NUM_CH = 2,
   parameter int W      = 4
);
   logic [NUM_CH-1:0]   hold_req;
   logic [NUM_CH*W-1:0] level;
   logic [NUM_CH-1:0]   shield_ok;
   logic [NUM_CH-1:0]   broken;
   logic [NUM_CH-1:0]   full;

   modport master (
      output hold_req,
      input  level,
      input  shield_ok,
      input  broken,
      input  full
   );

   modport slave (
      input  hold_req,
      output level,
      output shield_ok,
      output broken,
      output full
   );
endinterface

// File: rtl/shield_meter_channel.sv
// One shield meter: READY/DRAIN/DELAY/REGEN/BROKEN FSM with saturating
// drain/regen, a post-release regen delay and a lockout after depletion.
// hold_s must already be synchronous to slowed_shield_clk.
// BREAK_TICKS is expected to be at least 1.
module shield_meter_channel
   import shield_meter_bank_pkg::*;
#(
   parameter int W           = DEF_W,
   parameter int MAX_LVL     = DEF_MAX_LVL,
   parameter int DRAIN_STEP  = DEF_DRAIN_STEP,
   parameter int REGEN_STEP  = DEF_REGEN_STEP,
   parameter int REGEN_DELAY = DEF_REGEN_DELAY,
   parameter int BREAK_TICKS = DEF_BREAK_TICKS,
   parameter int MIN_USE     = DEF_MIN_USE
)(
   input  logic         slowed_shield_clk,
   input  logic         reset,
   input  logic         hold_s,
   output logic [W-1:0] level,
   output logic         shield_ok,
   output logic         broken,
   output logic         full
);

   localparam int DW = cnt_width(REGEN_DELAY);
   localparam int BW = cnt_width(BREAK_TICKS);

   localparam logic [W-1:0]  MAX_LW     = W'(MAX_LVL);
   localparam logic [W:0]    MAX_W1     = (W+1)'(MAX_LVL);
   localparam logic [W:0]    MIN_W1     = (W+1)'(MIN_USE);
   localparam logic [W:0]    DRAIN_W1   = (W+1)'(DRAIN_STEP);
   localparam logic [W:0]    REGEN_W1   = (W+1)'(REGEN_STEP);
   localparam logic [DW-1:0] DELAY_INIT = (REGEN_DELAY == 0) ? '0 : DW'(REGEN_DELAY - 1);
   localparam logic [BW-1:0] BREAK_INIT = BW'(BREAK_TICKS - 1);

   meter_state_e  state_q, state_d;
   logic [W-1:0]  level_q, level_d;
   logic [DW-1:0] delay_cnt_q, delay_cnt_d;
   logic [BW-1:0] break_cnt_q, break_cnt_d;
   logic          rearm_q, rearm_d;
   logic          shield_ok_q, shield_ok_d;
   logic          broken_q, broken_d;
   logic          full_q, full_d;

   logic          do_drain;
   logic [W:0]    drain_w1, regen_w1;
   logic [W-1:0]  drain_lvl, regen_lvl;

   // Saturating arithmetic in W+1 bits: the extra bit catches the borrow
   // below 0 and the overshoot above MAX_LVL.
   assign drain_w1  = {1'b0, level_q} - DRAIN_W1;
   assign drain_lvl = drain_w1[W] ? '0 : drain_w1[W-1:0];
   assign regen_w1  = {1'b0, level_q} + REGEN_W1;
   assign regen_lvl = (regen_w1 > MAX_W1) ? MAX_LW : regen_w1[W-1:0];

   // Next-state, counters, rearm and the registered status outputs.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves one unassigned, which would infer a latch.
      state_d     = state_q;
      level_d     = level_q;
      delay_cnt_d = delay_cnt_q;
      break_cnt_d = break_cnt_q;
      rearm_d     = rearm_q | ~hold_s;
      do_drain    = 1'b0;

      case (state_q)
         ST_READY: begin
            if (hold_s && rearm_q) do_drain = 1'b1;
         end
         ST_DRAIN: begin
            if (hold_s) begin
               do_drain = 1'b1;
            end else if (REGEN_DELAY == 0) begin
               state_d = ST_REGEN;
            end else begin
               state_d     = ST_DELAY;
               delay_cnt_d = DELAY_INIT;
            end
         end
         ST_DELAY: begin
            if (hold_s) begin
               do_drain = 1'b1;
            end else if (delay_cnt_q == '0) begin
               state_d = ST_REGEN;
            end else begin
               delay_cnt_d = delay_cnt_q - DW'(1);
            end
         end
         ST_REGEN: begin
            if (hold_s && rearm_q && ({1'b0, level_q} >= MIN_W1)) begin
               do_drain = 1'b1;
            end else begin
               level_d = regen_lvl;
               if (regen_lvl == MAX_LW) state_d = ST_READY;
            end
         end
         ST_BROKEN: begin
            // Button is ignored during lockout; only the timer matters.
            if (break_cnt_q == '0) state_d = ST_REGEN;
            else                   break_cnt_d = break_cnt_q - BW'(1);
         end
         default: state_d = ST_READY;
      endcase

      // Every entry into DRAIN applies one drain step on the same edge.
      if (do_drain) begin
         level_d = drain_lvl;
         if (drain_lvl == '0) begin
            state_d     = ST_BROKEN;
            break_cnt_d = BREAK_INIT;
            rearm_d     = 1'b0;
         end else begin
            state_d = ST_DRAIN;
         end
      end

      shield_ok_d = (state_d != ST_BROKEN) && rearm_d && ({1'b0, level_d} >= MIN_W1);
      broken_d    = (state_d == ST_BROKEN);
      full_d      = (level_d == MAX_LW);
   end

   // Meter state register with synchronous active-low reset.
   always_ff @(posedge slowed_shield_clk) begin
      // NOTE: reset is sampled on the clock edge only; it is not in the
      // sensitivity list, so a reset pulse between edges has no effect.
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples its pre-edge inputs regardless of statement order.
         state_q     <= ST_READY;
         level_q     <= MAX_LW;
         delay_cnt_q <= '0;
         break_cnt_q <= '0;
         rearm_q     <= 1'b1;
         shield_ok_q <= 1'b1;
         broken_q    <= 1'b0;
         full_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         delay_cnt_q <= delay_cnt_d;
         break_cnt_q <= break_cnt_d;
         rearm_q     <= rearm_d;
         shield_ok_q <= shield_ok_d;
         broken_q    <= broken_d;
         full_q      <= full_d;
      end
   end

   assign level     = level_q;
   assign shield_ok = shield_ok_q;
   assign broken    = broken_q;
   assign full      = full_q;

endmodule

// File: rtl/shield_meter_bank.sv
// Bank of NUM_CH independent shield meters on the 2 Hz slowed_shield_clk.
// Fast-domain hold requests pass through a SYNC_STAGES-deep synchroniser
// per channel before reaching that channel's meter FSM.
module shield_meter_bank
   import shield_meter_bank_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int W           = DEF_W,
   parameter int MAX_LVL     = DEF_MAX_LVL,
   parameter int DRAIN_STEP  = DEF_DRAIN_STEP,
   parameter int REGEN_STEP  = DEF_REGEN_STEP,
   parameter int REGEN_DELAY = DEF_REGEN_DELAY,
   parameter int BREAK_TICKS = DEF_BREAK_TICKS,
   parameter int MIN_USE     = DEF_MIN_USE,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
)(
   input  logic               slowed_shield_clk,
   input  logic               reset,
   shield_meter_bank_if.slave bus
);

   logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [NUM_CH-1:0]                  hold_s;
   logic [W-1:0]                       ch_level [NUM_CH];
   logic [NUM_CH-1:0]                  ch_ok, ch_broken, ch_full;
   logic [NUM_CH*W-1:0]                level_flat;

   // Shift each request one stage deeper; the last stage is the meter's view.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], bus.hold_req[c]};
         hold_s[c] = sync_q[c][SYNC_STAGES-1];
      end
   end

   // Synchroniser flops, cleared on reset so a held button restarts the latency.
   always_ff @(posedge slowed_shield_clk) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      shield_meter_channel #(
         .W           (W),
         .MAX_LVL     (MAX_LVL),
         .DRAIN_STEP  (DRAIN_STEP),
         .REGEN_STEP  (REGEN_STEP),
         .REGEN_DELAY (REGEN_DELAY),
         .BREAK_TICKS (BREAK_TICKS),
         .MIN_USE     (MIN_USE)
      ) u_ch (
         .slowed_shield_clk (slowed_shield_clk),
         .reset             (reset),
         .hold_s            (hold_s[c]),
         .level             (ch_level[c]),
         .shield_ok         (ch_ok[c]),
         .broken            (ch_broken[c]),
         .full              (ch_full[c])
      );
   end

   // Pack per-channel levels with channel c at [c*W +: W].
   always_comb begin
      level_flat = '0;
      for (int c = 0; c < NUM_CH; c++) level_flat[c*W +: W] = ch_level[c];
   end

   assign bus.level     = level_flat;
   assign bus.shield_ok = ch_ok;
   assign bus.broken    = ch_broken;
   assign bus.full      = ch_full;

endmodule

// File: tb/tb_shield_meter_bank.sv
// Directed bench for shield_meter_bank with default parameters.
// Edge numbering: the reset edge is edge 0; every later posedge counts up.
module tb_shield_meter_bank;

   localparam int NUM_CH = 2;
   localparam int W      = 4;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   edge_n = 0;

   shield_meter_bank_if #(.NUM_CH(NUM_CH), .W(W)) bus ();

   shield_meter_bank #(.NUM_CH(NUM_CH), .W(W)) dut (
      .slowed_shield_clk (clk),
      .reset             (reset),
      .bus               (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] lvl(input int c);
      return bus.level[c*W +: W];
   endfunction

   // Advance one active edge and settle at the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      edge_n++;
   endtask

   task automatic test_reset();
      bus.hold_req = '0;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      edge_n = 0;
      checks++;
      if (bus.level !== 8'hFF) begin
         errors++;
         $display("FAIL reset level: got %h expected ff", bus.level);
      end
      checks++;
      if (bus.shield_ok !== 2'b11) begin
         errors++;
         $display("FAIL reset shield_ok: got %b expected 11", bus.shield_ok);
      end
      checks++;
      if (bus.full !== 2'b11) begin
         errors++;
         $display("FAIL reset full: got %b expected 11", bus.full);
      end
      checks++;
      if (bus.broken !== 2'b00) begin
         errors++;
         $display("FAIL reset broken: got %b expected 00", bus.broken);
      end
      reset = 1'b1;
   endtask

   // Hold channel 0 from before edge 1 until it breaks at edge 17.
   task automatic test_drain_to_break();
      int exp_l;
      bus.hold_req = 2'b01;
      for (int e = 1; e <= 17; e++) begin
         tick();
         exp_l = (e < 3) ? 15 : 17 - e;
         checks++;
         if (lvl(0) !== 4'(exp_l)) begin
            errors++;
            $display("FAIL drain edge %0d level0: got %0d expected %0d", e, lvl(0), exp_l);
         end
         checks++;
         if (lvl(1) !== 4'd15) begin
            errors++;
            $display("FAIL drain edge %0d level1: got %0d expected 15", e, lvl(1));
         end
      end
      checks++;
      if (bus.broken !== 2'b01) begin
         errors++;
         $display("FAIL break broken: got %b expected 01", bus.broken);
      end
      checks++;
      if (bus.shield_ok !== 2'b10) begin
         errors++;
         $display("FAIL break shield_ok: got %b expected 10", bus.shield_ok);
      end
      checks++;
      if (bus.full !== 2'b10) begin
         errors++;
         $display("FAIL break full: got %b expected 10", bus.full);
      end
   endtask

   // Keep holding through lockout, then release and regen to full.
   task automatic test_lockout_rearm();
      int   exp_l;
      logic exp_b, exp_ok, exp_f;
      for (int e = 18; e <= 36; e++) begin
         if (e == 24) bus.hold_req[0] = 1'b0;
         tick();
         exp_l  = (e <= 21) ? 0 : e - 21;
         exp_b  = (e <= 20);
         exp_ok = (e >= 26);
         exp_f  = (e == 36);
         checks++;
         if (lvl(0) !== 4'(exp_l)) begin
            errors++;
            $display("FAIL lockout edge %0d level0: got %0d expected %0d", e, lvl(0), exp_l);
         end
         checks++;
         if (bus.broken[0] !== exp_b) begin
            errors++;
            $display("FAIL lockout edge %0d broken0: got %b expected %b", e, bus.broken[0], exp_b);
         end
         checks++;
         if (bus.shield_ok[0] !== exp_ok) begin
            errors++;
            $display("FAIL lockout edge %0d shield_ok0: got %b expected %b", e, bus.shield_ok[0], exp_ok);
         end
         checks++;
         if (bus.full[0] !== exp_f) begin
            errors++;
            $display("FAIL lockout edge %0d full0: got %b expected %b", e, bus.full[0], exp_f);
         end
      end
   endtask

   // Drain to 10, release: two delay ticks, then regen back to full.
   task automatic test_delay_regen();
      logic hold_pat [15];
      int   exp_l    [15];
      hold_pat = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      exp_l    = '{15, 15, 14, 13, 12, 11, 10, 10, 10, 10, 11, 12, 13, 14, 15};
      for (int i = 0; i < 15; i++) begin
         bus.hold_req[0] = hold_pat[i];
         tick();
         checks++;
         if (lvl(0) !== 4'(exp_l[i])) begin
            errors++;
            $display("FAIL delay edge %0d level0: got %0d expected %0d", edge_n, lvl(0), exp_l[i]);
         end
         checks++;
         if (bus.full[0] !== (exp_l[i] == 15)) begin
            errors++;
            $display("FAIL delay edge %0d full0: got %b expected %b", edge_n, bus.full[0], exp_l[i] == 15);
         end
         checks++;
         if (bus.shield_ok[0] !== 1'b1) begin
            errors++;
            $display("FAIL delay edge %0d shield_ok0: got %b expected 1", edge_n, bus.shield_ok[0]);
         end
      end
   endtask

   // Re-hold during DELAY resumes draining; the next release restarts the delay.
   task automatic test_delay_reassert();
      logic hold_pat [18];
      int   exp_l    [18];
      hold_pat = '{1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      exp_l    = '{15, 15, 14, 13, 12, 11, 10, 10, 9, 9, 9, 9, 10, 11, 12, 13, 14, 15};
      for (int i = 0; i < 18; i++) begin
         bus.hold_req[0] = hold_pat[i];
         tick();
         checks++;
         if (lvl(0) !== 4'(exp_l[i])) begin
            errors++;
            $display("FAIL reassert edge %0d level0: got %0d expected %0d", edge_n, lvl(0), exp_l[i]);
         end
      end
   endtask

   // Drain both channels together to 7, reset mid-drain, check synchroniser clear.
   task automatic test_reset_mid_drain();
      int exp_l;
      bus.hold_req = 2'b11;
      for (int k = 0; k < 10; k++) begin
         tick();
         exp_l = (k < 2) ? 15 : 16 - k;
         checks++;
         if (bus.level !== {4'(exp_l), 4'(exp_l)}) begin
            errors++;
            $display("FAIL dual drain step %0d level: got %h expected %h", k, bus.level, {4'(exp_l), 4'(exp_l)});
         end
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (bus.level !== 8'hFF) begin
         errors++;
         $display("FAIL mid reset level: got %h expected ff", bus.level);
      end
      checks++;
      if (bus.shield_ok !== 2'b11 || bus.full !== 2'b11 || bus.broken !== 2'b00) begin
         errors++;
         $display("FAIL mid reset flags: got ok=%b full=%b broken=%b expected 11 11 00",
                  bus.shield_ok, bus.full, bus.broken);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         exp_l = (k < 3) ? 15 : 14;
         checks++;
         if (bus.level !== {4'(exp_l), 4'(exp_l)}) begin
            errors++;
            $display("FAIL post reset step %0d level: got %h expected %h", k, bus.level, {4'(exp_l), 4'(exp_l)});
         end
      end
   endtask

   initial begin
      test_reset();
      test_drain_to_break();
      test_lockout_rearm();
      test_delay_regen();
      test_delay_reassert();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
